// File: rtl/traffic_pkg.sv
// Shared light encodings and phase enumeration for the intersection controller.
// Pure declarations: no logic, no latency, no flow control.
package traffic_pkg;

    typedef logic [2:0] light_t;

    localparam light_t LIGHT_RED    = 3'b001;
    localparam light_t LIGHT_YELLOW = 3'b010;
    localparam light_t LIGHT_GREEN  = 3'b100;

    typedef enum logic [2:0] {
        ALL_RED_TO_NS = 3'd0,
        NS_GREEN      = 3'd1,
        NS_YELLOW     = 3'd2,
        ALL_RED_TO_EW = 3'd3,
        EW_GREEN      = 3'd4,
        EW_YELLOW     = 3'd5
    } phase_t;

endpackage

// File: rtl/car_release_timer.sv
// Paces car releases for one direction while it is green: dec_car fires every PASS_INTERVAL cycles.
// Pulse is combinational from registered pass_cnt and car_in_queue; no backpressure, a lost release is not retried.
module car_release_timer #(
    parameter int PASS_INTERVAL = 2
) (
    input  logic traffic_clk,
    input  logic reset,
    input  logic enable,
    input  logic car_in_queue,
    output logic dec_car
);

    localparam int W = (PASS_INTERVAL > 1) ? $clog2(PASS_INTERVAL) : 1;
    localparam logic [W-1:0] PASS_LAST = W'(PASS_INTERVAL - 1);

    logic [W-1:0] pass_cnt;

    // Held at zero while disabled so every green entry starts a fresh interval.
    always_ff @(posedge traffic_clk) begin
        if (reset || !enable) begin
            pass_cnt <= '0;
        end else if (pass_cnt == PASS_LAST) begin
            pass_cnt <= '0;
        end else begin
            pass_cnt <= pass_cnt + W'(1);
        end
    end

    assign dec_car = enable && (pass_cnt == PASS_LAST) && car_in_queue;

endmodule

// File: rtl/intersection_light_ctrl.sv
// Two-direction light sequencer with green dwell bounded by GREEN_MIN/GREEN_MAX when the cross queue waits.
// Lights are a Moore decode of the registered phase; release pulses go straight back to the queues, no backpressure.
module intersection_light_ctrl
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN     = 4,
    parameter int GREEN_MAX     = 10,
    parameter int YELLOW_TIME   = 2,
    parameter int ALL_RED_TIME  = 1,
    parameter int PASS_INTERVAL = 2
) (
    input  logic       traffic_clk,
    input  logic       reset,
    input  logic       ns_car_in_queue,
    input  logic [3:0] ns_car_count,
    input  logic       ew_car_in_queue,
    input  logic [3:0] ew_car_count,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       ns_dec_car,
    output logic       ew_dec_car,
    output logic [2:0] phase_state
);

    localparam int CW = $clog2(GREEN_MAX + 1);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t GMIN_LAST = cnt_t'(GREEN_MIN - 1);
    localparam cnt_t GMAX_LAST = cnt_t'(GREEN_MAX - 1);
    localparam cnt_t YEL_LAST  = cnt_t'(YELLOW_TIME - 1);
    localparam cnt_t RED_LAST  = cnt_t'(ALL_RED_TIME - 1);

    phase_t state;
    cnt_t   phase_cnt;
    logic   ns_leave;
    logic   ew_leave;
    logic   unused_counts;

    // Counts are display-only; decisions use the occupancy flags alone.
    assign unused_counts = ^{ns_car_count, ew_car_count};

    assign ns_leave = ew_car_in_queue &&
                      ((phase_cnt >= GMIN_LAST && !ns_car_in_queue) || phase_cnt >= GMAX_LAST);
    assign ew_leave = ns_car_in_queue &&
                      ((phase_cnt >= GMIN_LAST && !ew_car_in_queue) || phase_cnt >= GMAX_LAST);

    always_ff @(posedge traffic_clk) begin
        if (reset) begin
            state     <= ALL_RED_TO_NS;
            phase_cnt <= '0;
        end else begin
            case (state)
                ALL_RED_TO_NS: begin
                    if (phase_cnt == RED_LAST) begin
                        state     <= NS_GREEN;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + cnt_t'(1);
                    end
                end
                NS_GREEN: begin
                    if (ns_leave) begin
                        state     <= NS_YELLOW;
                        phase_cnt <= '0;
                    end else if (phase_cnt != GMAX_LAST) begin
                        phase_cnt <= phase_cnt + cnt_t'(1);
                    end
                end
                NS_YELLOW: begin
                    if (phase_cnt == YEL_LAST) begin
                        state     <= ALL_RED_TO_EW;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + cnt_t'(1);
                    end
                end
                ALL_RED_TO_EW: begin
                    if (phase_cnt == RED_LAST) begin
                        state     <= EW_GREEN;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + cnt_t'(1);
                    end
                end
                EW_GREEN: begin
                    if (ew_leave) begin
                        state     <= EW_YELLOW;
                        phase_cnt <= '0;
                    end else if (phase_cnt != GMAX_LAST) begin
                        phase_cnt <= phase_cnt + cnt_t'(1);
                    end
                end
                EW_YELLOW: begin
                    if (phase_cnt == YEL_LAST) begin
                        state     <= ALL_RED_TO_NS;
                        phase_cnt <= '0;
                    end else begin
                        phase_cnt <= phase_cnt + cnt_t'(1);
                    end
                end
                default: begin
                    state     <= ALL_RED_TO_NS;
                    phase_cnt <= '0;
                end
            endcase
        end
    end

    assign ns_light = (state == NS_GREEN)  ? LIGHT_GREEN  :
                      (state == NS_YELLOW) ? LIGHT_YELLOW : LIGHT_RED;
    assign ew_light = (state == EW_GREEN)  ? LIGHT_GREEN  :
                      (state == EW_YELLOW) ? LIGHT_YELLOW : LIGHT_RED;
    assign phase_state = state;

    car_release_timer #(.PASS_INTERVAL(PASS_INTERVAL)) u_ns_release (
        .traffic_clk  (traffic_clk),
        .reset        (reset),
        .enable       (state == NS_GREEN),
        .car_in_queue (ns_car_in_queue),
        .dec_car      (ns_dec_car)
    );

    car_release_timer #(.PASS_INTERVAL(PASS_INTERVAL)) u_ew_release (
        .traffic_clk  (traffic_clk),
        .reset        (reset),
        .enable       (state == EW_GREEN),
        .car_in_queue (ew_car_in_queue),
        .dec_car      (ew_dec_car)
    );

endmodule

// File: tb/tb_intersection_light_ctrl.sv
// Bench for intersection_light_ctrl: behavioural phase/queue model checked every cycle, plus directed literal checks.
module tb_intersection_light_ctrl;

    localparam int GREEN_MIN     = 4;
    localparam int GREEN_MAX     = 10;
    localparam int YELLOW_TIME   = 2;
    localparam int ALL_RED_TIME  = 1;
    localparam int PASS_INTERVAL = 2;

    logic       traffic_clk = 1'b0;
    logic       reset = 1'b1;
    logic       ns_car_in_queue = 1'b0;
    logic [3:0] ns_car_count = 4'd0;
    logic       ew_car_in_queue = 1'b0;
    logic [3:0] ew_car_count = 4'd0;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic       ns_dec_car;
    logic       ew_dec_car;
    logic [2:0] phase_state;

    intersection_light_ctrl #(
        .GREEN_MIN     (GREEN_MIN),
        .GREEN_MAX     (GREEN_MAX),
        .YELLOW_TIME   (YELLOW_TIME),
        .ALL_RED_TIME  (ALL_RED_TIME),
        .PASS_INTERVAL (PASS_INTERVAL)
    ) dut (
        .traffic_clk     (traffic_clk),
        .reset           (reset),
        .ns_car_in_queue (ns_car_in_queue),
        .ns_car_count    (ns_car_count),
        .ew_car_in_queue (ew_car_in_queue),
        .ew_car_count    (ew_car_count),
        .ns_light        (ns_light),
        .ew_light        (ew_light),
        .ns_dec_car      (ns_dec_car),
        .ew_dec_car      (ew_dec_car),
        .phase_state     (phase_state)
    );

    always #5 traffic_clk = ~traffic_clk;

    int total = 0;
    int bad   = 0;

    // Phase index walks 0..5 in the fixed cycle order; lights per phase as tables.
    int ns_tab [6] = '{1, 4, 2, 1, 1, 1};
    int ew_tab [6] = '{1, 1, 1, 1, 4, 2};

    int nsq = 0;
    int ewq = 0;
    int m_phase = 0;
    int m_t = 0;
    bit m_valid = 0;

    int ns_green_cycles, ew_green_cycles, ns_pulses, ew_pulses;
    logic [2:0] last_ns_light, last_ew_light, last_phase;
    logic       last_ns_dec, last_ew_dec;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_obs();
        ns_green_cycles = 0;
        ew_green_cycles = 0;
        ns_pulses = 0;
        ew_pulses = 0;
    endtask

    task automatic step(input bit rst, input bit add_ns, input bit add_ew);
        bit nsin, ewin, exp_ns_dec, exp_ew_dec, leave;
        @(negedge traffic_clk);
        reset           = rst;
        ns_car_in_queue = (nsq != 0);
        ns_car_count    = 4'(nsq);
        ew_car_in_queue = (ewq != 0);
        ew_car_count    = 4'(ewq);
        #1;
        nsin = (nsq != 0);
        ewin = (ewq != 0);
        exp_ns_dec = m_valid && m_phase == 1 && (m_t % PASS_INTERVAL) == PASS_INTERVAL - 1 && nsin;
        exp_ew_dec = m_valid && m_phase == 4 && (m_t % PASS_INTERVAL) == PASS_INTERVAL - 1 && ewin;
        if (m_valid) begin
            check("ns_light", ns_light, ns_tab[m_phase]);
            check("ew_light", ew_light, ew_tab[m_phase]);
            check("phase_state", phase_state, m_phase);
            check("ns_dec_car", ns_dec_car, exp_ns_dec);
            check("ew_dec_car", ew_dec_car, exp_ew_dec);
            check("light_exclusive", $onehot(ns_light) && $onehot(ew_light) &&
                  (ns_light == 3'b001 || ew_light == 3'b001), 1);
        end
        last_ns_light = ns_light;
        last_ew_light = ew_light;
        last_phase    = phase_state;
        last_ns_dec   = ns_dec_car;
        last_ew_dec   = ew_dec_car;
        if (ns_light == 3'b100) ns_green_cycles++;
        if (ew_light == 3'b100) ew_green_cycles++;
        if (ns_dec_car === 1'b1) ns_pulses++;
        if (ew_dec_car === 1'b1) ew_pulses++;

        if (rst) begin
            m_phase = 0;
            m_t     = 0;
            m_valid = 1;
        end else if (m_valid) begin
            case (m_phase)
                0, 3:    leave = m_t >= ALL_RED_TIME - 1;
                2, 5:    leave = m_t >= YELLOW_TIME - 1;
                1:       leave = ewin && ((m_t >= GREEN_MIN - 1 && !nsin) || m_t >= GREEN_MAX - 1);
                default: leave = nsin && ((m_t >= GREEN_MIN - 1 && !ewin) || m_t >= GREEN_MAX - 1);
            endcase
            if (leave) begin
                m_phase = (m_phase + 1) % 6;
                m_t     = 0;
            end else begin
                m_t++;
            end
        end
        // Upstream queue: add wins over a simultaneous release.
        if (add_ns) nsq = (nsq < 15) ? nsq + 1 : 15;
        else if (exp_ns_dec) nsq--;
        if (add_ew) ewq = (ewq < 15) ? ewq + 1 : 15;
        else if (exp_ew_dec) ewq--;
    endtask

    task automatic do_reset(input int ns_init, input int ew_init);
        nsq = ns_init;
        ewq = ew_init;
        step(1, 0, 0);
        step(1, 0, 0);
        clear_obs();
    endtask

    initial begin
        int n;

        // No cars: one all-red cycle, then NS rests in green without releases.
        step(1, 0, 0);
        do_reset(0, 0);
        step(0, 0, 0);
        check("s1_first_all_red", last_phase, 0);
        repeat (30) step(0, 0, 0);
        check("s1_rest_ns_green", last_phase, 1);
        check("s1_no_pulses", ns_pulses + ew_pulses, 0);

        // NS preloaded with 3: three releases, then rest in green.
        do_reset(3, 0);
        repeat (20) step(0, 0, 0);
        check("s2_ns_pulses", ns_pulses, 3);
        check("s2_ns_count", nsq, 0);
        check("s2_still_green", last_phase, 1);

        // EW waiting, NS empty: NS green exactly GREEN_MIN, then EW serves all 5.
        do_reset(0, 5);
        repeat (30) step(0, 0, 0);
        check("s3_ns_green_len", ns_green_cycles, 4);
        check("s3_ew_pulses", ew_pulses, 5);
        check("s3_ew_count", ewq, 0);
        check("s3_ew_resting", last_phase, 4);

        // Both saturated with continuous adds: GREEN_MAX dwell, releases lost.
        do_reset(15, 15);
        repeat (14) step(0, 1, 1);
        check("s4_ns_green_len", ns_green_cycles, 10);
        check("s4_ns_pulses", ns_pulses, 5);
        check("s4_ns_count", nsq, 15);
        repeat (12) step(0, 1, 1);
        check("s4_ew_green_len", ew_green_cycles, 10);
        check("s4_ew_yellow", last_ew_light, 3'b010);

        // Reset landing in EW_YELLOW aborts straight to all-red.
        do_reset(0, 5);
        n = 0;
        while (m_phase != 5 && n < 60) begin
            step(0, m_phase == 4, 0);
            n++;
        end
        check("s5_reached_ew_yellow", m_phase, 5);
        step(1, 0, 0);
        check("s5_pre_reset_yellow", last_ew_light, 3'b010);
        step(0, 0, 0);
        check("s5_ns_red", last_ns_light, 3'b001);
        check("s5_ew_red", last_ew_light, 3'b001);
        check("s5_phase", last_phase, 0);
        check("s5_no_dec", {last_ns_dec, last_ew_dec}, 0);
        step(0, 0, 0);
        check("s5_ns_green_next", last_ns_light, 3'b100);

        // Random arrivals; every cycle checked against the model.
        do_reset(0, 0);
        repeat (2000) step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
